fadd_p: RTL and testbench
=========================

Name: fadd_p

Overview:
- Parametrised, handshaked successor of the fixed 32-bit 4-stage pipelined FP adder.
- IEEE-754-style adder/subtractor with configurable exponent and mantissa widths, a per-operation add/sub mode and a passthrough tag.
- Valid/ready flow control with full-pipeline stall, so it can sit behind a scheduler and in front of a result bus that may backpressure.

Parameters:
- EW, 8, exponent width (≥4).
- MW, 23, stored mantissa width (≥4).
- TAGW, 4, width of opaque tag carried alongside each operation.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operands presented.
- in_ready  out  1  block accepts operands this cycle.
- sub  in  1  0: y = x1 + x2; 1: y = x1 − x2.
- x1  in  1+EW+MW  operand 1 {s,e,m}.
- x2  in  1+EW+MW  operand 2 {s,e,m}.
- tag_in  in  TAGW  opaque tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- y  out  1+EW+MW  result.
- ovf  out  1  finite operands produced ±inf.
- tag_out  out  TAGW  tag of the result.

Behaviour:
Clock and reset:
- One clock `clk`; `rst` is synchronous and active-high.
- Reset clears stage valid bits v1..v4 and the output registers: out_valid=0, y=0, ovf=0, tag_out=0.
- in_ready=1 in the first cycle after reset.
- Reset mid-operation discards every in-flight op; no partial result is emitted.

Flow control:
- adv = out_ready | ~v4. in_ready = adv (combinational).
- Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
- When adv=1, every stage register loads from its predecessor, v1 <= in_valid, and vk <= v(k-1).
- When adv=0, every register holds; y, ovf and tag_out remain stable while out_valid=1.
- Latency: exactly 4 cycles from accept to out_valid with no stall. Throughput: 1 op/cycle.
- Bubbles are not compressed (global stall, not elastic).

Effective operand:
- s2' = s2 ^ sub; all further rules use s2'.

Stage 1:
- Unpack each operand: e=0 → hidden bit 0 and exponent treated as 1; otherwise hidden bit 1.
- Compute exponent difference (EW+1 bits) and classify inf/NaN/zero.

Stage 2:
- Larger operand = greater exponent; on equal exponents, greater mantissa; on full tie, x2.
- Result sign = sign of the larger operand.
- Shift the smaller mantissa right by d, saturated at MW+3 (beyond that only sticky remains).
- Keep guard and round bits; OR all shifted-out bits into sticky.
- Add if signs equal, subtract otherwise, in MW+4 bits.

Stage 3:
- On carry out, shift right 1, fold the LSB into sticky and increment the exponent.
- Leading-zero count; normalise left, limited so the exponent does not drop below 1.
- If the exponent would drop below 1, emit a denormal with e=0 (gradual underflow, no flush-to-zero).

Stage 4 (rounding and special cases):
- Round to nearest, ties to even. Round up if G & (R|S|L), where L is the LSB.
- Mantissa overflow after rounding increments the exponent; a denormal rounding up to 1.0·2^emin becomes e=1.
- Finite result with exponent reaching all-ones → y = ±inf, ovf=1.
- Exact zero → sign = s1 & s2' (+0 unless both negative).
- NaN operand → quiet NaN: payload of the NaN operand, with x2's NaN taking priority when both are NaN; quiet bit forced to 1.
- inf ± inf with equal effective signs → that inf.
- inf ± inf with opposite effective signs → {1, all ones, 1, 0…}.
- Exactly one inf → that inf with its effective sign.
- ovf=0 whenever either input is inf or NaN.

Test Plan:
- x1=0x3F800000, x2=0x3F800000, sub=0, tag=5, no stall → 4 cycles later y=0x40000000, ovf=0, tag_out=5.
- x1=x2=0x3F800000, sub=1 → y=0x00000000. Same op with x1=x2=0xBF800000, sub=0 → y=0xC0000000.
- Rounding: 0x3F800000+0x33800000 → 0x3F800000 (tie to even); 0x3F800000+0x33C00000 → 0x3F800001; 0x00000001+0x00000001 → 0x00000002.
- Overflow and specials:
  - 0x7F7FFFFF+0x7F7FFFFF → 0x7F800000, ovf=1.
  - 0x7F800000, sub=1, x2=0x7F800000 → 0xFFC00000, ovf=0.
  - 0x7FC00001+0x3F800000 → 0x7FC00001.
- Backpressure:
  - Stream 8 ops on consecutive cycles; hold out_ready=0 for cycles 6–9.
  - Require in_ready=0 exactly while v4=1 and out_ready=0, and y/tag_out stable during the stall.
  - All 8 results emitted in order with correct tags; none lost or duplicated.
- Assert rst with 3 ops in flight → next cycle out_valid=0, y=0. Issue a new op → its result is the only one seen, 4 cycles after accept.

Source files
------------

// File: rtl/fadd_p.sv
// rtl/fadd_p.sv - parametrised 4-stage pipelined FP adder/subtractor with valid/ready global stall
module fadd_p #(
    parameter int EW   = 8,
    parameter int MW   = 23,
    parameter int TAGW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sub,
    input  logic [EW+MW:0]    x1,
    input  logic [EW+MW:0]    x2,
    input  logic [TAGW-1:0]   tag_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EW+MW:0]    y,
    output logic              ovf,
    output logic [TAGW-1:0]   tag_out
);
    localparam int FW = 1 + EW + MW;
    localparam int XW = MW + 4;              // hidden + mantissa + guard/round/sticky
    localparam int SW = $clog2(XW);
    localparam logic [EW-1:0] EMAX = '1;
    localparam logic [FW-1:0] QBIT = FW'(1) << (MW - 1);

    logic adv, v1, v2, v3;
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    // Stage 1: unpack, exponent difference, special-case result
    logic            s1_c, s2_c, nan1, nan2, inf1, inf2, spec1_c;
    logic [EW-1:0]   e1_c, e2_c;
    logic [MW:0]     m1_c, m2_c;
    logic [FW-1:0]   spec_y1_c;
    assign s1_c = x1[FW-1];
    assign s2_c = x2[FW-1] ^ sub;
    assign e1_c = (x1[FW-2:MW] == '0) ? EW'(1) : x1[FW-2:MW];
    assign e2_c = (x2[FW-2:MW] == '0) ? EW'(1) : x2[FW-2:MW];
    assign m1_c = {|x1[FW-2:MW], x1[MW-1:0]};
    assign m2_c = {|x2[FW-2:MW], x2[MW-1:0]};
    assign nan1 = (x1[FW-2:MW] == EMAX) &  (|x1[MW-1:0]);
    assign inf1 = (x1[FW-2:MW] == EMAX) & ~(|x1[MW-1:0]);
    assign nan2 = (x2[FW-2:MW] == EMAX) &  (|x2[MW-1:0]);
    assign inf2 = (x2[FW-2:MW] == EMAX) & ~(|x2[MW-1:0]);

    always_comb begin
        spec1_c   = 1'b1;
        spec_y1_c = '0;
        if (nan2)
            spec_y1_c = x2 | QBIT;
        else if (nan1)
            spec_y1_c = x1 | QBIT;
        else if (inf1 & inf2)
            spec_y1_c = (s1_c == s2_c) ? {s1_c, EMAX, MW'(0)} : {1'b1, EMAX, 1'b1, (MW-1)'(0)};
        else if (inf1)
            spec_y1_c = {s1_c, EMAX, MW'(0)};
        else if (inf2)
            spec_y1_c = {s2_c, EMAX, MW'(0)};
        else
            spec1_c = 1'b0;
    end

    logic            r1_s1, r1_s2, r1_spec;
    logic [EW-1:0]   r1_e1, r1_e2;
    logic [EW:0]     r1_d;
    logic [MW:0]     r1_m1, r1_m2;
    logic [FW-1:0]   r1_spec_y;
    logic [TAGW-1:0] r1_tag;

    // Stage 2: pick the larger operand, align the smaller one, add or subtract
    logic            x1_big, d_zero;
    logic [EW:0]     ad;
    logic [SW-1:0]   sh2;
    logic [XW-1:0]   big2, small2, al2;
    logic [2*XW-1:0] wide2;
    logic [XW:0]     sum2_c;
    assign d_zero = (r1_d == '0);
    assign x1_big = (~r1_d[EW] & ~d_zero) | (d_zero & (r1_m1 > r1_m2));
    assign ad     = r1_d[EW] ? -r1_d : r1_d;
    assign sh2    = (32'(ad) > MW + 3) ? SW'(MW + 3) : SW'(ad);
    assign big2   = x1_big ? {r1_m1, 3'b000} : {r1_m2, 3'b000};
    assign small2 = x1_big ? {r1_m2, 3'b000} : {r1_m1, 3'b000};
    assign wide2  = {small2, XW'(0)} >> sh2;
    assign al2    = wide2[2*XW-1:XW] | {{(XW-1){1'b0}}, |wide2[XW-1:0]};
    assign sum2_c = (r1_s1 == r1_s2) ? {1'b0, big2} + {1'b0, al2} : {1'b0, big2} - {1'b0, al2};

    logic            r2_sgn, r2_spec, r2_zs;
    logic [EW-1:0]   r2_exp;
    logic [XW:0]     r2_sum;
    logic [FW-1:0]   r2_spec_y;
    logic [TAGW-1:0] r2_tag;

    // Stage 3: carry renormalise or left-normalise, stopping at exponent 1 (denormal)
    logic [XW-1:0]   mant3_c;
    logic [EW:0]     exp3_c;
    int              lz, lim, sh3;
    always_comb begin
        lz = XW;
        for (int i = 0; i < XW; i++)
            if (r2_sum[i]) lz = XW - 1 - i;
        lim = int'(r2_exp) - 1;
        sh3 = (lz < lim) ? lz : lim;
        if (r2_sum[XW]) begin
            mant3_c = {r2_sum[XW:2], r2_sum[1] | r2_sum[0]};
            exp3_c  = {1'b0, r2_exp} + 1'b1;
        end else begin
            mant3_c = r2_sum[XW-1:0] << sh3;
            exp3_c  = {1'b0, r2_exp} - (EW+1)'(sh3);
        end
    end

    logic            r3_sgn, r3_spec, r3_zs;
    logic [EW:0]     r3_exp;
    logic [XW-1:0]   r3_mant;
    logic [FW-1:0]   r3_spec_y;
    logic [TAGW-1:0] r3_tag;

    // Stage 4: round to nearest even, then overflow / zero / special selection
    logic            hid4, up4, ovf4;
    logic [MW+1:0]   mr4;
    logic [EW:0]     ef4;
    logic [FW-1:0]   y4;
    assign hid4 = r3_mant[XW-1];
    assign up4  = r3_mant[2] & (r3_mant[1] | r3_mant[0] | r3_mant[3]);
    assign mr4  = {1'b0, r3_mant[XW-1:3]} + (MW+2)'(up4);
    assign ef4  = hid4 ? r3_exp + (EW+1)'(mr4[MW+1]) : (EW+1)'(mr4[MW]);

    always_comb begin
        y4   = {r3_sgn, ef4[EW-1:0], mr4[MW-1:0]};
        ovf4 = 1'b0;
        if (r3_spec) begin
            y4 = r3_spec_y;
        end else if (r3_mant == '0) begin
            y4 = {r3_zs, (FW-1)'(0)};
        end else if (ef4 >= {1'b0, EMAX}) begin
            y4   = {r3_sgn, EMAX, MW'(0)};
            ovf4 = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            out_valid <= 1'b0;
            y         <= '0;
            ovf       <= 1'b0;
            tag_out   <= '0;
        end else if (adv) begin
            v1        <= in_valid;
            v2        <= v1;
            v3        <= v2;
            out_valid <= v3;
            y         <= y4;
            ovf       <= ovf4;
            tag_out   <= r3_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            r1_s1     <= s1_c;
            r1_s2     <= s2_c;
            r1_e1     <= e1_c;
            r1_e2     <= e2_c;
            r1_d      <= {1'b0, e1_c} - {1'b0, e2_c};
            r1_m1     <= m1_c;
            r1_m2     <= m2_c;
            r1_spec   <= spec1_c;
            r1_spec_y <= spec_y1_c;
            r1_tag    <= tag_in;
            r2_sgn    <= x1_big ? r1_s1 : r1_s2;
            r2_exp    <= x1_big ? r1_e1 : r1_e2;
            r2_sum    <= sum2_c;
            r2_spec   <= r1_spec;
            r2_spec_y <= r1_spec_y;
            r2_zs     <= r1_s1 & r1_s2;
            r2_tag    <= r1_tag;
            r3_sgn    <= r2_sgn;
            r3_exp    <= exp3_c;
            r3_mant   <= mant3_c;
            r3_spec   <= r2_spec;
            r3_spec_y <= r2_spec_y;
            r3_zs     <= r2_zs;
            r3_tag    <= r2_tag;
        end
    end
endmodule

// File: tb/tb_fadd_p.sv
// tb/tb_fadd_p.sv - self-checking bench for fadd_p against an exact-arithmetic reference
module tb_fadd_p;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, sub, out_valid, out_ready, ovf;
    logic [31:0] x1, x2, y;
    logic [3:0]  tag_in, tag_out;

    always #5 clk = ~clk;

    fadd_p #(.EW(8), .MW(23), .TAGW(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sub(sub),
        .x1(x1), .x2(x2), .tag_in(tag_in), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .ovf(ovf), .tag_out(tag_out)
    );

    typedef struct {
        logic [31:0] y;
        logic        ovf;
        logic [3:0]  tag;
        int          stg;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0, failures = 0;
    bit          use_dir = 1'b0;
    logic [31:0] dir_y;
    logic        dir_ovf;
    bit          acc;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", name, obs, expv);
        end
    endtask

    // Exact sum on a 2^-149 fixed-point grid, then a single round-to-nearest-even to binary32.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub_b);
        logic         s_a, s_b, s;
        int           ea, eb, p, sh, e;
        logic [299:0] av, bv, mag, qm, rem, half;
        s_a = a[31];
        s_b = b[31] ^ sub_b;
        ea  = int'(a[30:23]);
        eb  = int'(b[30:23]);
        if (eb == 255 && b[22:0] != 0) return {1'b0, b | 32'h0040_0000};
        if (ea == 255 && a[22:0] != 0) return {1'b0, a | 32'h0040_0000};
        if (ea == 255 && eb == 255)
            return (s_a == s_b) ? {1'b0, s_a, 8'hFF, 23'h0} : {1'b0, 32'hFFC0_0000};
        if (ea == 255) return {1'b0, s_a, 8'hFF, 23'h0};
        if (eb == 255) return {1'b0, s_b, 8'hFF, 23'h0};
        av = (ea == 0) ? 300'(a[22:0]) : (300'({1'b1, a[22:0]}) << (ea - 1));
        bv = (eb == 0) ? 300'(b[22:0]) : (300'({1'b1, b[22:0]}) << (eb - 1));
        if (s_a == s_b) begin
            mag = av + bv; s = s_a;
        end else if (av >= bv) begin
            mag = av - bv; s = s_a;
        end else begin
            mag = bv - av; s = s_b;
        end
        if (mag == 0) return {1'b0, s_a & s_b, 31'h0};
        p = 0;
        for (int i = 0; i < 300; i++)
            if (mag[i]) p = i;
        if (p <= 23) return {1'b0, s, mag[30:0]};
        sh   = p - 23;
        qm   = mag >> sh;
        rem  = mag & ((300'(1) << sh) - 300'(1));
        half = 300'(1) << (sh - 1);
        if (rem > half || (rem == half && qm[0])) qm = qm + 300'(1);
        e = sh + 1;
        if (qm[24]) begin
            qm = qm >> 1;
            e++;
        end
        if (e >= 255) return {1'b1, s, 8'hFF, 23'h0};
        return {1'b0, s, 8'(e), qm[22:0]};
    endfunction

    function automatic logic [31:0] rfp();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 9))
            0: v[30:23] = 8'h00;
            1: v[30:23] = 8'hFF;
            2: v[30:0]  = 31'h0;
            3: v[30:23] = 8'hFE;
            4: v[30:23] = 8'h01;
            default: ;
        endcase
        return v;
    endfunction

    // One clock: compare outputs against the global-stall occupancy model, then update it.
    task automatic cycle(output bit accepted);
        exp_t        e;
        logic [32:0] r;
        bit          ov_exp, adv_exp;
        #1;
        ov_exp  = (sb_q.size() > 0) && (sb_q[0].stg == 4);
        adv_exp = out_ready || !ov_exp;
        chk("out_valid", {31'h0, out_valid}, {31'h0, ov_exp});
        chk("in_ready", {31'h0, in_ready}, {31'h0, adv_exp});
        if (ov_exp) begin
            chk("y", y, sb_q[0].y);
            chk("ovf", {31'h0, ovf}, {31'h0, sb_q[0].ovf});
            chk("tag_out", {28'h0, tag_out}, {28'h0, sb_q[0].tag});
        end
        accepted = in_valid && adv_exp;
        if (adv_exp) begin
            if (ov_exp) void'(sb_q.pop_front());
            foreach (sb_q[i]) sb_q[i].stg++;
            if (accepted) begin
                r     = use_dir ? {dir_ovf, dir_y} : model(x1, x2, sub);
                e.y   = r[31:0];
                e.ovf = r[32];
                e.tag = tag_in;
                e.stg = 1;
                sb_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        bit a;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (sb_q.size() > 0 && n < 40) begin
            cycle(a);
            n++;
        end
        chk("drain_left", 32'(sb_q.size()), 32'd0);
        cycle(a);
    endtask

    task automatic dop(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [3:0] t, input logic [31:0] ey, input logic eo);
        bit a_ok;
        x1 = a; x2 = b; sub = s; tag_in = t;
        in_valid = 1'b1; out_ready = 1'b1;
        use_dir = 1'b1; dir_y = ey; dir_ovf = eo;
        cycle(a_ok);
        use_dir = 1'b0;
        in_valid = 1'b0;
        chk("dir_accept", {31'h0, a_ok}, 32'd1);
        drain();
    endtask

    initial begin
        int k;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sub = 1'b0;
        x1 = '0; x2 = '0; tag_in = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_y", y, 32'h0);
        chk("rst_ovf", {31'h0, ovf}, 32'd0);
        chk("rst_tag", {28'h0, tag_out}, 32'd0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'd1);

        dop(32'h3F80_0000, 32'h3F80_0000, 1'b0, 4'd5, 32'h4000_0000, 1'b0);
        dop(32'h3F80_0000, 32'h3F80_0000, 1'b1, 4'd1, 32'h0000_0000, 1'b0);
        dop(32'hBF80_0000, 32'hBF80_0000, 1'b0, 4'd2, 32'hC000_0000, 1'b0);
        dop(32'h3F80_0000, 32'h3380_0000, 1'b0, 4'd3, 32'h3F80_0000, 1'b0);
        dop(32'h3F80_0000, 32'h33C0_0000, 1'b0, 4'd4, 32'h3F80_0001, 1'b0);
        dop(32'h0000_0001, 32'h0000_0001, 1'b0, 4'd6, 32'h0000_0002, 1'b0);
        dop(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 4'd7, 32'h7F80_0000, 1'b1);
        dop(32'h7F80_0000, 32'h7F80_0000, 1'b1, 4'd8, 32'hFFC0_0000, 1'b0);
        dop(32'h7FC0_0001, 32'h3F80_0000, 1'b0, 4'd9, 32'h7FC0_0001, 1'b0);
        dop(32'hBF80_0000, 32'h3F80_0000, 1'b1, 4'd10, 32'hC000_0000, 1'b0);

        // Backpressure: 8 back-to-back ops with out_ready low for cycles 6..9
        k = 0;
        for (int t = 0; t < 40 && (k < 8 || sb_q.size() > 0); t++) begin
            out_ready = !(t >= 6 && t <= 9);
            in_valid  = (k < 8);
            if (acc || t == 0) begin
                x1 = rfp(); x2 = rfp(); sub = 1'($urandom_range(0, 1));
            end
            tag_in = 4'(k + 1);
            cycle(acc);
            if (acc) k++;
        end
        chk("bp_issued", 32'(k), 32'd8);
        drain();

        // Reset with three ops in flight
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            x1 = rfp(); x2 = rfp(); sub = 1'b0; tag_in = 4'(i + 11);
            in_valid = 1'b1;
            cycle(acc);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        chk("midrst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("midrst_y", y, 32'h0);
        dop(32'h4040_0000, 32'h3F80_0000, 1'b0, 4'd14, 32'h4080_0000, 1'b0);

        // Randomised traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            x1 = rfp();
            x2 = rfp();
            if ($urandom_range(0, 1) == 1) x2[30:23] = x1[30:23] ^ 8'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) x2 = x1;
            sub    = 1'($urandom_range(0, 1));
            tag_in = 4'($urandom_range(0, 15));
            cycle(acc);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
